// File: rtl/config_pkg.sv
// Shared configuration for the interrupt pending path.
// Holds the default interrupt vector count, the pend-bit write record
// exchanged with the interrupt controller, and the pend_ctrl FSM states.
package config_pkg;

    localparam int VEC_SIZE  = 8;
    localparam int VEC_WIDTH = $clog2(VEC_SIZE);

    // One pend-bit write: which controller entry, and the value for its pended bit.
    typedef struct packed {
        logic [VEC_WIDTH-1:0] idx;
        logic                 val;
    } pend_req_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } pend_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// Searches the request vector starting one position after the last granted
// index and wrapping around, so every set request wins within VecSize grants.
//   req       : request vector, one bit per line
//   last      : index granted most recently
//   grant_idx : winning index (0 when no request is set)
//   any       : at least one request is set
module rr_arbiter #(
    parameter int  VecSize  = 8,
    localparam int VecWidth = $clog2(VecSize)
) (
    input  logic [VecSize-1:0]  req,
    input  logic [VecWidth-1:0] last,
    output logic [VecWidth-1:0] grant_idx,
    output logic                any
);

    int                  cand;
    logic [VecWidth-1:0] cand_idx;

    // NOTE: every output and temporary gets a default before the search so no
    // path through this block leaves a value unassigned, which would infer a latch.
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= VecSize; i++) begin
            cand     = (int'(last) + i) % VecSize;
            cand_idx = VecWidth'(cand);
            if (!any && req[cand_idx]) begin
                any       = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

endmodule

// File: rtl/pend_ctrl.sv
// Interrupt pend controller.
// Synchronizes raw interrupt lines, turns edges and level changes into
// pend-bit write requests, and offers them one at a time to the interrupt
// controller's entry CSR with a valid/ready handshake.
//   clk        : clock, all state updates on its rising edge
//   reset      : asynchronous active-low reset
//   irq_in     : raw asynchronous interrupt lines
//   pend_valid : pend-bit write request outstanding
//   pend_ready : controller accepts the request this cycle
//   pend_idx   : entry index to write
//   pend_val   : value for the entry's pended bit
//   ovr_clr    : per-line one-cycle clear of the overrun flag
//   overrun    : sticky per-line lost-event flag
module pend_ctrl
    import config_pkg::*;
#(
    parameter int                 VecSize    = VEC_SIZE,
    parameter logic [VecSize-1:0] EdgeMask   = {VecSize{1'b1}},
    parameter int                 SyncStages = 2,
    localparam int                VecWidth   = $clog2(VecSize)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [VecSize-1:0]  irq_in,
    output logic                pend_valid,
    input  logic                pend_ready,
    output logic [VecWidth-1:0] pend_idx,
    output logic                pend_val,
    input  logic [VecSize-1:0]  ovr_clr,
    output logic [VecSize-1:0]  overrun
);

    // SyncStages must be at least 2 for metastability protection.
    logic [VecSize-1:0]  sync_q [SyncStages];
    logic [VecSize-1:0]  sync_d [SyncStages];
    logic [VecSize-1:0]  hist_q, hist_d;
    logic [VecSize-1:0]  rise_q, rise_d;
    logic [VecSize-1:0]  edge_req_q, edge_req_d;
    logic [VecSize-1:0]  shadow_q, shadow_d;
    logic [VecSize-1:0]  ovr_q, ovr_d;
    pend_state_e         state_q, state_d;
    logic [VecWidth-1:0] idx_q, idx_d;
    logic                val_q, val_d;
    logic [VecWidth-1:0] last_q, last_d;

    logic [VecSize-1:0]  line_s;
    logic [VecSize-1:0]  level_req;
    logic [VecSize-1:0]  acc_vec;
    logic [VecSize-1:0]  arb_req;
    logic                accept;
    logic [VecWidth-1:0] grant;
    logic                arb_any;

    // ---------------- synchronizer and edge detector ----------------
    always_comb begin
        sync_d[0] = irq_in;
        for (int i = 1; i < SyncStages; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // NOTE: the synchronizer array is a handful of flops, not a RAM, so it is
    // reset like any other state; otherwise stale levels would fake edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SyncStages; i++) sync_q[i] <= '0;
        end else begin
            for (int i = 0; i < SyncStages; i++) sync_q[i] <= sync_d[i];
        end
    end

    assign line_s = sync_q[SyncStages-1];
    assign hist_d = line_s;
    // Edge pulse is registered so the detector gate stays out of the
    // req/arbiter path; this stage sets the edge latency to SyncStages+2.
    assign rise_d = line_s & ~hist_q & EdgeMask;

    // ---------------- per-line request bookkeeping ----------------
    assign accept    = (state_q == OFFER) && pend_ready;
    assign level_req = ~EdgeMask & (line_s ^ shadow_q);
    // The line being accepted is excluded so the next winner is a different request.
    assign arb_req   = (edge_req_q | level_req) & ~acc_vec;

    always_comb begin
        acc_vec = '0;
        if (accept) acc_vec[idx_q] = 1'b1;
    end

    always_comb begin
        edge_req_d = edge_req_q;
        shadow_d   = shadow_q;
        ovr_d      = ovr_q & ~ovr_clr;
        for (int k = 0; k < VecSize; k++) begin
            if (acc_vec[k]) begin
                edge_req_d[k] = 1'b0;
                if (!EdgeMask[k]) shadow_d[k] = val_q;
            end
            // A new edge always leaves the request set; it is lost (overrun)
            // only when the pending one is not being accepted this cycle.
            // Setting overrun after the clear gives set priority over ovr_clr.
            if (rise_q[k]) begin
                if (edge_req_q[k] && !acc_vec[k]) ovr_d[k] = 1'b1;
                edge_req_d[k] = 1'b1;
            end
        end
    end

    // ---------------- arbitration and offer FSM ----------------
    rr_arbiter #(
        .VecSize (VecSize)
    ) u_arb (
        .req       (arb_req),
        .last      (last_q),
        .grant_idx (grant),
        .any       (arb_any)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        val_d   = val_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = OFFER;
                    idx_d   = grant;
                    val_d   = EdgeMask[grant] | line_s[grant];
                    last_d  = grant;
                end
            end
            OFFER: begin
                // idx/val hold until the handshake completes.
                if (accept) begin
                    if (arb_any) begin
                        idx_d  = grant;
                        val_d  = EdgeMask[grant] | line_s[grant];
                        last_d = grant;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q     <= '0;
            rise_q     <= '0;
            edge_req_q <= '0;
            shadow_q   <= '0;
            ovr_q      <= '0;
            state_q    <= IDLE;
            idx_q      <= '0;
            val_q      <= 1'b0;
            last_q     <= VecWidth'(VecSize - 1);
        end else begin
            hist_q     <= hist_d;
            rise_q     <= rise_d;
            edge_req_q <= edge_req_d;
            shadow_q   <= shadow_d;
            ovr_q      <= ovr_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            val_q      <= val_d;
            last_q     <= last_d;
        end
    end

    assign pend_valid = (state_q == OFFER);
    assign pend_idx   = idx_q;
    assign pend_val   = val_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_pend_ctrl.sv
// Self-checking bench for pend_ctrl: reset state, a table of simultaneous
// edge patterns with round-robin order and latency, hand sequences for
// hold/overrun, level lines and reset mid-offer, and a randomized run
// checked against an event-counting reference model.
module tb_pend_ctrl;
    import config_pkg::*;

    localparam int         SYNC      = 2;
    localparam logic [7:0] EDGE_MASK = 8'hEF;   // line 4 is a level source
    localparam int         LVL       = 4;

    logic       clk;
    logic       reset;
    logic [7:0] irq_in;
    logic       pend_valid;
    logic       pend_ready;
    logic [2:0] pend_idx;
    logic       pend_val;
    logic [7:0] ovr_clr;
    logic [7:0] overrun;

    pend_ctrl #(
        .VecSize    (8),
        .EdgeMask   (EDGE_MASK),
        .SyncStages (SYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .pend_valid (pend_valid),
        .pend_ready (pend_ready),
        .pend_idx   (pend_idx),
        .pend_val   (pend_val),
        .ovr_clr    (ovr_clr),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int        cyc;
        pend_req_t r;
    } xfer_t;

    typedef struct {
        logic [7:0]  edges;
        int          n;
        logic [31:0] seq;   // expected idx order, one hex digit each, MSB first
    } row_t;

    int         n_tests;
    int         n_fail;
    int         cycle;
    xfer_t      xq[$];
    int         events[8];
    logic [7:0] prev_samp;
    int         stab_err;
    logic       hold_prev;
    pend_req_t  hold_req;
    row_t       rows[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge after inputs are driven; observes what the next
    // posedge will see, then advances to the following negedge.
    task automatic tick();
        xfer_t x;
        #1;
        if (reset) begin
            if (hold_prev && !(pend_valid && pend_idx == hold_req.idx && pend_val == hold_req.val))
                stab_err++;
            hold_prev    = pend_valid && !pend_ready;
            hold_req.idx = pend_idx;
            hold_req.val = pend_val;
            if (pend_valid && pend_ready) begin
                x.cyc   = cycle;
                x.r.idx = pend_idx;
                x.r.val = pend_val;
                xq.push_back(x);
            end
            for (int k = 0; k < 8; k++)
                if (irq_in[k] && !prev_samp[k]) events[k]++;
            prev_samp = irq_in;
        end else begin
            hold_prev = 1'b0;
            prev_samp = '0;
        end
        cycle++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && !pend_valid; i++) tick();
        check($sformatf("%s valid within %0d", name, max_cycles), pend_valid, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        int          c0;
        int          xf[8];
        int          bad_val;
        int          bad_alt;
        logic        lvl_last;

        n_tests = 0; n_fail = 0; cycle = 0; stab_err = 0;
        hold_prev = 1'b0; hold_req = '0; prev_samp = '0;
        for (int k = 0; k < 8; k++) events[k] = 0;
        reset = 1'b0; irq_in = '0; ovr_clr = '0; pend_ready = 1'b0;

        rows[0] = '{8'h62, 3, 32'h1560_0000};
        rows[1] = '{8'h42, 2, 32'h1600_0000};
        rows[2] = '{8'h08, 1, 32'h3000_0000};
        rows[3] = '{8'h81, 2, 32'h7000_0000};
        rows[4] = '{8'h0C, 2, 32'h2300_0000};
        rows[5] = '{8'hEF, 7, 32'h5670_1230};

        // ---------------- reset state ----------------
        @(negedge clk);
        #1;
        check("reset pend_valid", pend_valid, 0);
        check("reset pend_idx", pend_idx, 0);
        check("reset pend_val", pend_val, 0);
        check("reset overrun", overrun, 0);
        @(negedge clk);
        run(2);
        reset = 1'b1;
        run(5);
        check("idle after release", pend_valid, 0);

        // ---------------- table: simultaneous edges, ready tied high ----------------
        pend_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            xq.delete();
            c0 = cycle;
            irq_in = rows[r].edges;
            run(20);
            irq_in = '0;
            run(8);
            s = rows[r].seq;
            check($sformatf("row%0d count", r), xq.size(), rows[r].n);
            for (int j = 0; j < rows[r].n && j < xq.size(); j++) begin
                check($sformatf("row%0d idx%0d", r, j), xq[j].r.idx, s[31-4*j -: 4]);
                check($sformatf("row%0d val%0d", r, j), xq[j].r.val, 1);
                check($sformatf("row%0d cycle%0d", r, j), xq[j].cyc - c0, SYNC + 3 + j);
            end
        end

        // ---------------- hold under backpressure, overrun ----------------
        pend_ready = 1'b0;
        xq.delete();
        irq_in[2] = 1'b1;
        wait_valid("offer2", 20);
        for (int i = 0; i < 10; i++) begin
            if (i == 1) irq_in[2] = 1'b0;
            if (i == 3) irq_in[2] = 1'b1;
            tick();
            check($sformatf("hold cycle%0d", i), {pend_valid, pend_idx, pend_val}, {1'b1, 3'd2, 1'b1});
        end
        check("overrun after 2nd edge", overrun, 8'h04);
        ovr_clr[2] = 1'b1;
        tick();
        ovr_clr = '0;
        check("overrun cleared", overrun, 8'h00);
        irq_in[2] = 1'b0;
        run(3);
        irq_in[2] = 1'b1;
        run(3);
        ovr_clr[2] = 1'b1;   // same cycle the new edge is processed
        tick();
        ovr_clr = '0;
        tick();
        check("overrun set beats clear", overrun, 8'h04);
        check("still holding", {pend_valid, pend_idx, pend_val}, {1'b1, 3'd2, 1'b1});
        pend_ready = 1'b1;
        run(5);
        irq_in = '0;
        run(6);
        check("merged edges one xfer", xq.size(), 1);
        if (xq.size() >= 1) check("merged xfer idx", xq[0].r.idx, 2);
        ovr_clr = 8'hFF;
        tick();
        ovr_clr = '0;

        // ---------------- level line ----------------
        xq.delete();
        irq_in[LVL] = 1'b1;
        run(10);
        irq_in[LVL] = 1'b0;
        run(10);
        check("level count", xq.size(), 2);
        if (xq.size() >= 2) begin
            check("level rise", xq[0].r, {3'd4, 1'b1});
            check("level fall", xq[1].r, {3'd4, 1'b0});
        end
        xq.delete();
        irq_in[LVL] = 1'b1;
        #2;
        irq_in[LVL] = 1'b0;
        run(10);
        check("short glitch filtered", xq.size(), 0);
        xq.delete();
        irq_in[LVL] = 1'b1;
        tick();
        irq_in[LVL] = 1'b0;
        run(12);
        check("captured pulse count", xq.size(), 2);
        if (xq.size() >= 2) begin
            check("pulse rise", xq[0].r, {3'd4, 1'b1});
            check("pulse fall", xq[1].r, {3'd4, 1'b0});
        end

        // ---------------- reset mid-offer ----------------
        pend_ready = 1'b0;
        xq.delete();
        irq_in[5] = 1'b1;
        wait_valid("offer5", 20);
        irq_in[5] = 1'b0;
        run(3);
        irq_in[5] = 1'b1;
        run(6);
        check("overrun5 before reset", overrun[5], 1);
        #2;
        reset = 1'b0;
        #1;
        check("async reset drops valid", pend_valid, 0);
        check("async reset clears overrun", overrun, 8'h00);
        irq_in = 8'h10;          // edge line low, level line high across release
        @(negedge clk);
        run(2);
        reset = 1'b1;
        pend_ready = 1'b1;
        run(20);
        check("post-reset xfers", xq.size(), 1);
        if (xq.size() >= 1) check("level high at release", xq[0].r, {3'd4, 1'b1});
        irq_in = '0;
        run(10);

        // ---------------- randomized run vs event-counting model ----------------
        reset = 1'b0;
        run(2);
        reset = 1'b1;
        xq.delete();
        for (int k = 0; k < 8; k++) events[k] = 0;
        for (int i = 0; i < 10000; i++) begin
            for (int k = 0; k < 8; k++)
                if ($urandom_range(7) == 0) irq_in[k] = ~irq_in[k];
            pend_ready = ($urandom_range(3) != 0);
            tick();
        end
        pend_ready = 1'b1;
        run(40);

        for (int k = 0; k < 8; k++) xf[k] = 0;
        bad_val  = 0;
        bad_alt  = 0;
        lvl_last = 1'b0;
        foreach (xq[j]) begin
            xf[xq[j].r.idx]++;
            if (xq[j].r.idx == 3'(LVL)) begin
                if (xq[j].r.val != ~lvl_last) bad_alt++;
                lvl_last = xq[j].r.val;
            end else if (xq[j].r.val != 1'b1) begin
                bad_val++;
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (k == LVL) continue;
            if (overrun[k])
                check($sformatf("rand line%0d lost with overrun", k),
                      (xf[k] < events[k]) && (xf[k] >= 1), 1);
            else
                check($sformatf("rand line%0d xfers=edges", k), xf[k], events[k]);
        end
        check("rand edge vals", bad_val, 0);
        check("rand level alternation", bad_alt, 0);
        check("rand level shadow", lvl_last, irq_in[LVL]);
        check("offer stability", stab_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pend_ctrl.md
PEND_CTRL -- requirements
Module: pend_ctrl

Interface
REQ-001 SHALL have parameter VecSize, default 8, number of interrupt lines (matches interrupt controller vector count).
REQ-002 SHALL have parameter EdgeMask, default all ones (VecSize bits), per line: 1 = rising-edge source, 0 = level source.
REQ-003 SHALL have parameter SyncStages, default 2, synchronizer depth, minimum 2.
REQ-004 SHALL derive VecWidth = $clog2(VecSize).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 irq_in  input  VecSize  raw, asynchronous interrupt lines.
REQ-008 pend_valid  output  1  pend-bit write request to interrupt controller entry CSR.
REQ-009 pend_ready  input  1  controller accepts request this cycle.
REQ-010 pend_idx  output  VecWidth  entry index to write.
REQ-011 pend_val  output  1  value for entry pended bit.
REQ-012 ovr_clr  input  VecSize  per-line one-cycle clear of overrun flag.
REQ-013 overrun  output  VecSize  sticky per-line lost-event flag.

Function
REQ-014 Each irq_in bit SHALL pass through SyncStages flops, then one history flop for edge detection.
REQ-015 Edge line: synchronized 0->1 transition SHALL set req[k]; pend_val for that line SHALL be 1.
REQ-016 Edge line: transition while req[k] already set and not being accepted that cycle SHALL set overrun[k]; req[k] stays set.
REQ-017 Edge line: transition in the same cycle req[k] is accepted SHALL leave req[k] set, no overrun.
REQ-018 Level line: req[k] SHALL be asserted whenever synchronized level differs from shadow[k]; pend_val = synchronized level at selection.
REQ-019 Level line: on acceptance shadow[k] SHALL take the accepted pend_val; a level change back before acceptance SHALL cancel the request only if no offer is outstanding for k.
REQ-020 FSM SHALL have states IDLE and OFFER.
REQ-021 IDLE: any req set -> select round-robin winner starting at index after last granted, register pend_idx/pend_val, go OFFER.
REQ-022 OFFER: pend_valid = 1; pend_idx, pend_val SHALL remain stable until pend_valid && pend_ready.
REQ-023 OFFER accept: clear req[idx] (edge) or update shadow (level); if another req set, select next winner and remain OFFER (one transfer per cycle); else go IDLE.
REQ-024 Latency: isolated edge with controller idle, irq_in stable before clock edge 0 -> pend_valid high after clock edge SyncStages+2.
REQ-025 Round-robin SHALL guarantee every set req is granted within VecSize accepted transfers.
REQ-026 overrun[k]: set has priority over simultaneous ovr_clr[k].
REQ-027 pend_ready while pend_valid = 0 SHALL be ignored.

Reset
REQ-028 Asserting reset (low) SHALL asynchronously clear sync/history flops, req, shadow, overrun, last-grant pointer (to VecSize-1), FSM to IDLE, pend_valid/pend_idx/pend_val to 0.
REQ-029 Reset mid-offer SHALL drop the outstanding request without a transfer; no event is replayed after release.
REQ-030 Level lines high at reset release SHALL produce a request after the synchronizer latency.

Structure
REQ-031 VecSize default and pend_req_t (packed idx, val) SHALL live in config_pkg, shared with the interrupt controller.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, last pointer in; grant index, any out; combinational).
REQ-033 Synchronizers SHALL be plain flop chains inside pend_ctrl, no sub-module.

Verification
REQ-034 Edge on line 3, pend_ready tied 1 -> single transfer idx 3 val 1 at cycle SyncStages+2, pend_valid low next cycle.
REQ-035 Edges on lines 1, 5, 6 same cycle, ready 1 -> transfers 1, 5, 6 on consecutive cycles; then edge on 1 and 6 -> 6 first only if pointer rule says so (pointer at 6 -> 1 then 6).
REQ-036 pend_ready low 10 cycles during offer idx 2 -> idx/val stable all 10 cycles; second edge on line 2 -> overrun[2] = 1; ovr_clr[2] same cycle as new edge -> overrun stays 1.
REQ-037 EdgeMask bit 4 = 0, irq_in[4] high then low -> transfer idx 4 val 1, then idx 4 val 0; high pulse of 1 cycle -> filtered only if not captured by synchronizer.
REQ-038 Reset asserted during OFFER -> pend_valid 0 immediately (asynchronously), all overrun 0, no transfer after release.
REQ-039 Random irq_in, random pend_ready, 10k cycles -> scoreboard: no lost edge without overrun, level shadows match synchronized lines when quiescent.
